scan_vector_sequencer: RTL and testbench
========================================

SCAN_VECTOR_SEQUENCER -- requirements
Module: scan_vector_sequencer

Interface
REQ-001 SHALL have parameters: NUM_CHAINS, default 4, number of scan chains; LEN_W, default 16, chain-length field width; WFT_W, default 4, waveform-table index width.
REQ-002 SHALL have ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- start  in  1  begin session (pulse)
- cfg_chain_len  in  LEN_W  shift cycles per pattern, 1..65535
- cfg_shift_wft  in  WFT_W  table for shift cycles
- cfg_capture_wft  in  WFT_W  table for capture cycle
- vec_valid  in  1  beat available
- vec_ready  out  1  beat accepted when valid&ready
- vec_si  in  NUM_CHAINS  scan-in bits for one shift cycle
- vec_so_exp  in  NUM_CHAINS  expected scan-out bits
- vec_so_mask  in  NUM_CHAINS  1 = compare bit
- vec_last  in  1  beat belongs to final pattern
- scan_out_obs  in  NUM_CHAINS  sampled DUT scan-out
- tester_sync  out  1  one-cycle pulse per issued tester cycle
- wft  out  WFT_W  table index of issued cycle
- si_drive  out  NUM_CHAINS  scan-in values of issued cycle
- capture  out  1  issued cycle is capture
- cycle_number  out  32  count of issued cycles
- vector_number  out  32  count of completed patterns
- busy  out  1  session active
- done  out  1  one-cycle pulse at session end
- mismatch_cnt  out  16  failing compared bits, saturating
- fail  out  1  sticky, mismatch_cnt nonzero

Function
REQ-003 SHALL implement FSM IDLE, SHIFT, CAPTURE, DONE.
REQ-004 IDLE -> SHIFT on start; shift counter cleared; cycle_number, vector_number, mismatch_cnt, fail cleared in the same cycle.
REQ-005 In SHIFT, vec_ready SHALL be 1; vec_ready is 0 in all other states.
- Per accepted beat, next cycle: tester_sync=1, wft=cfg_shift_wft, si_drive=vec_si, capture=0, cycle_number+1.
REQ-006 In SHIFT with vec_valid=0, SHALL issue no cycle (tester_sync=0, outputs hold); no timeout.
REQ-007 On acceptance of beat cfg_chain_len within a pattern -> CAPTURE.
- Issue one cycle with wft=cfg_capture_wft, capture=1, si_drive held, no beat consumed.
REQ-008 After CAPTURE, vector_number SHALL increment.
- If the last accepted beat had vec_last=1 -> DONE, else -> SHIFT with shift counter cleared.
REQ-009 DONE SHALL pulse done for one cycle, then -> IDLE.
REQ-010 start SHALL be ignored outside IDLE.
REQ-011 busy SHALL be 1 in SHIFT and CAPTURE.
REQ-012 Compare SHALL be evaluated one cycle after each issued shift cycle: mismatch_cnt += popcount((scan_out_obs ^ registered so_exp) & registered so_mask).
- Saturates at 16'hFFFF.
- Capture cycles are not compared.
REQ-013 cycle_number and vector_number SHALL wrap modulo 2^32.
REQ-014 cfg_* SHALL be sampled at start and held for the session.
- cfg_chain_len=0 SHALL be treated as 1.

Reset
REQ-015 On reset=1 at a clock edge: state=IDLE; all outputs 0 (vec_ready, tester_sync, wft, si_drive, capture, cycle_number, vector_number, busy, done, mismatch_cnt, fail); pending compare discarded.
REQ-016 Reset mid-session SHALL abort without a done pulse; next start begins a fresh session.

Configuration
REQ-017 Macro SCAN_SEQ_COMPARE_EN defined: REQ-012 compare logic present.
REQ-018 Macro SCAN_SEQ_COMPARE_EN undefined: compare logic absent, mismatch_cnt=0 and fail=0 constantly, vec_so_exp/vec_so_mask/scan_out_obs ignored.

Structure
REQ-019 Package scan_seq_pkg SHALL hold the state enum, NUM_CHAINS/LEN_W/WFT_W defaults and the mismatch-counter saturation constant.
REQ-020 Sub-module scan_seq_compare SHALL hold the compare pipeline register, popcount and saturating counter.

Verification
REQ-021 chain_len=3, 2 patterns, vec_valid always 1 -> 8 tester_sync pulses (S,S,S,C,S,S,S,C), vector_number=2, one done pulse, cycle_number=8.
REQ-022 chain_len=4, vec_valid low 5 cycles after beat 2 -> no tester_sync during stall; capture issued after beat 4; cycle_number=5.
REQ-023 exp=4'b1010, mask=4'b1111, obs=4'b0101 on one shift -> mismatch_cnt=4, fail=1; same case with mask=4'b0000 -> mismatch_cnt=0.
REQ-024 reset asserted in SHIFT after beat 2 -> all outputs 0 next cycle, no done; new start runs a clean session from cycle_number=0.
REQ-025 start pulsed during SHIFT -> ignored, counters unaffected; cfg_chain_len=0 -> one shift then capture.
REQ-026 build without SCAN_SEQ_COMPARE_EN, mismatching data -> mismatch_cnt=0, fail=0, sequencing identical to REQ-021.

Source files
------------

// File: rtl/scan_seq_pkg.sv
// Shared types and defaults for the scan vector sequencer.
// Build option SCAN_SEQ_COMPARE_EN (see scan_vector_sequencer) selects the scan-out compare.
package scan_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } seq_state_e;

    localparam int NUM_CHAINS_DEF = 4;
    localparam int LEN_W_DEF      = 16;
    localparam int WFT_W_DEF      = 4;

    localparam logic [15:0] MISMATCH_SAT = 16'hFFFF;

endpackage

// File: rtl/scan_seq_compare.sv
// Scan-out compare: expected/mask pipeline, popcount of failing bits, saturating
// mismatch counter. Only instantiated when SCAN_SEQ_COMPARE_EN is defined.
module scan_seq_compare
    import scan_seq_pkg::*;
#(
    parameter int NUM_CHAINS = NUM_CHAINS_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  issue,
    input  logic [NUM_CHAINS-1:0] so_exp,
    input  logic [NUM_CHAINS-1:0] so_mask,
    input  logic [NUM_CHAINS-1:0] scan_out_obs,
    output logic [15:0]           mismatch_cnt,
    output logic                  fail
);

    // Stage "iss" lines up with the issued tester cycle, stage "cmp" with the
    // following cycle, where the observed scan-out is judged.
    logic                  iss_pend_q, iss_pend_d;
    logic [NUM_CHAINS-1:0] iss_exp_q, iss_exp_d;
    logic [NUM_CHAINS-1:0] iss_mask_q, iss_mask_d;
    logic                  cmp_pend_q, cmp_pend_d;
    logic [NUM_CHAINS-1:0] cmp_exp_q, cmp_exp_d;
    logic [NUM_CHAINS-1:0] cmp_mask_q, cmp_mask_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [NUM_CHAINS-1:0] diff;
    logic [16:0]           pop;
    logic [16:0]           sum;

    always_comb begin
        iss_pend_d = issue;
        iss_exp_d  = so_exp;
        iss_mask_d = so_mask;
        cmp_pend_d = iss_pend_q;
        cmp_exp_d  = iss_exp_q;
        cmp_mask_d = iss_mask_q;
        cnt_d      = cnt_q;

        diff = (scan_out_obs ^ cmp_exp_q) & cmp_mask_q;
        pop  = '0;
        for (int i = 0; i < NUM_CHAINS; i++) begin
            pop = pop + 17'(diff[i]);
        end
        sum = {1'b0, cnt_q} + pop;

        if (cmp_pend_q) begin
            cnt_d = (sum > {1'b0, MISMATCH_SAT}) ? MISMATCH_SAT : sum[15:0];
        end

        if (clear) begin
            iss_pend_d = 1'b0;
            cmp_pend_d = 1'b0;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            iss_pend_q <= 1'b0;
            iss_exp_q  <= '0;
            iss_mask_q <= '0;
            cmp_pend_q <= 1'b0;
            cmp_exp_q  <= '0;
            cmp_mask_q <= '0;
            cnt_q      <= '0;
        end else begin
            iss_pend_q <= iss_pend_d;
            iss_exp_q  <= iss_exp_d;
            iss_mask_q <= iss_mask_d;
            cmp_pend_q <= cmp_pend_d;
            cmp_exp_q  <= cmp_exp_d;
            cmp_mask_q <= cmp_mask_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mismatch_cnt = cnt_q;
    assign fail         = (cnt_q != 16'd0);

endmodule

// File: rtl/scan_vector_sequencer.sv
// Streams scan beats into tester cycles (shift..shift, capture) per pattern.
// Define SCAN_SEQ_COMPARE_EN to include the scan-out compare and mismatch counter.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for start; config sampled on start
// ST_SHIFT   | accepting beats, one shift tester cycle per accepted beat
// ST_CAPTURE | issuing the capture cycle that closes the pattern
// ST_DONE    | one-cycle done pulse, then back to idle
module scan_vector_sequencer
    import scan_seq_pkg::*;
#(
    parameter int NUM_CHAINS = NUM_CHAINS_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int WFT_W      = WFT_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_W-1:0]      cfg_chain_len,
    input  logic [WFT_W-1:0]      cfg_shift_wft,
    input  logic [WFT_W-1:0]      cfg_capture_wft,
    input  logic                  vec_valid,
    output logic                  vec_ready,
    input  logic [NUM_CHAINS-1:0] vec_si,
    input  logic [NUM_CHAINS-1:0] vec_so_exp,
    input  logic [NUM_CHAINS-1:0] vec_so_mask,
    input  logic                  vec_last,
    input  logic [NUM_CHAINS-1:0] scan_out_obs,
    output logic                  tester_sync,
    output logic [WFT_W-1:0]      wft,
    output logic [NUM_CHAINS-1:0] si_drive,
    output logic                  capture,
    output logic [31:0]           cycle_number,
    output logic [31:0]           vector_number,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           mismatch_cnt,
    output logic                  fail
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    seq_state_e            state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic [WFT_W-1:0]      shift_wft_q, shift_wft_d;
    logic [WFT_W-1:0]      cap_wft_q, cap_wft_d;
    logic                  last_q, last_d;
    logic                  tester_sync_q, tester_sync_d;
    logic [WFT_W-1:0]      wft_q, wft_d;
    logic [NUM_CHAINS-1:0] si_drive_q, si_drive_d;
    logic                  capture_q, capture_d;
    logic [31:0]           cycle_q, cycle_d;
    logic [31:0]           vector_q, vector_d;
    logic                  accept;
    logic                  session_start;

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        rem_d         = rem_q;
        shift_wft_d   = shift_wft_q;
        cap_wft_d     = cap_wft_q;
        last_d        = last_q;
        tester_sync_d = 1'b0;
        wft_d         = wft_q;
        si_drive_d    = si_drive_q;
        capture_d     = capture_q;
        cycle_d       = cycle_q;
        vector_d      = vector_q;
        accept        = 1'b0;
        session_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    session_start = 1'b1;
                    state_d       = ST_SHIFT;
                    // A zero length would never reach terminal count; run it as one shift.
                    len_d         = (cfg_chain_len == '0) ? LEN_ONE : cfg_chain_len;
                    rem_d         = (cfg_chain_len == '0) ? LEN_ONE : cfg_chain_len;
                    shift_wft_d   = cfg_shift_wft;
                    cap_wft_d     = cfg_capture_wft;
                    cycle_d       = '0;
                    vector_d      = '0;
                end
            end
            ST_SHIFT: begin
                if (vec_valid) begin
                    accept        = 1'b1;
                    tester_sync_d = 1'b1;
                    wft_d         = shift_wft_q;
                    si_drive_d    = vec_si;
                    capture_d     = 1'b0;
                    cycle_d       = cycle_q + 32'd1;
                    last_d        = vec_last;
                    if (rem_q == LEN_ONE) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        rem_d = rem_q - LEN_ONE;
                    end
                end
            end
            ST_CAPTURE: begin
                tester_sync_d = 1'b1;
                wft_d         = cap_wft_q;
                capture_d     = 1'b1;
                cycle_d       = cycle_q + 32'd1;
                vector_d      = vector_q + 32'd1;
                if (last_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                    rem_d   = len_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            rem_q         <= '0;
            shift_wft_q   <= '0;
            cap_wft_q     <= '0;
            last_q        <= 1'b0;
            tester_sync_q <= 1'b0;
            wft_q         <= '0;
            si_drive_q    <= '0;
            capture_q     <= 1'b0;
            cycle_q       <= '0;
            vector_q      <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            rem_q         <= rem_d;
            shift_wft_q   <= shift_wft_d;
            cap_wft_q     <= cap_wft_d;
            last_q        <= last_d;
            tester_sync_q <= tester_sync_d;
            wft_q         <= wft_d;
            si_drive_q    <= si_drive_d;
            capture_q     <= capture_d;
            cycle_q       <= cycle_d;
            vector_q      <= vector_d;
        end
    end

    assign vec_ready     = (state_q == ST_SHIFT);
    assign busy          = (state_q == ST_SHIFT) || (state_q == ST_CAPTURE);
    assign done          = (state_q == ST_DONE);
    assign tester_sync   = tester_sync_q;
    assign wft           = wft_q;
    assign si_drive      = si_drive_q;
    assign capture       = capture_q;
    assign cycle_number  = cycle_q;
    assign vector_number = vector_q;

`ifdef SCAN_SEQ_COMPARE_EN
    scan_seq_compare #(
        .NUM_CHAINS (NUM_CHAINS)
    ) u_compare (
        .clock        (clock),
        .reset        (reset),
        .clear        (session_start),
        .issue        (accept),
        .so_exp       (vec_so_exp),
        .so_mask      (vec_so_mask),
        .scan_out_obs (scan_out_obs),
        .mismatch_cnt (mismatch_cnt),
        .fail         (fail)
    );
`else
    logic unused_cmp_inputs;
    assign unused_cmp_inputs = ^{vec_so_exp, vec_so_mask, scan_out_obs, accept, session_start};
    assign mismatch_cnt      = 16'd0;
    assign fail              = 1'b0;
`endif

endmodule

// File: tb/tb_scan_vector_sequencer.sv
// Directed bench: table of whole sessions with hand-computed tester-cycle traces,
// plus hand-written reset and reset-mid-session sequences.
module tb_scan_vector_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] cfg_chain_len;
    logic [3:0]  cfg_shift_wft;
    logic [3:0]  cfg_capture_wft;
    logic        vec_valid;
    logic        vec_ready;
    logic [3:0]  vec_si;
    logic [3:0]  vec_so_exp;
    logic [3:0]  vec_so_mask;
    logic        vec_last;
    logic [3:0]  scan_out_obs;
    logic        tester_sync;
    logic [3:0]  wft;
    logic [3:0]  si_drive;
    logic        capture;
    logic [31:0] cycle_number;
    logic [31:0] vector_number;
    logic        busy;
    logic        done;
    logic [15:0] mismatch_cnt;
    logic        fail;

`ifdef SCAN_SEQ_COMPARE_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    localparam logic [3:0] SH_WFT  = 4'h5;
    localparam logic [3:0] CAP_WFT = 4'hA;

    scan_vector_sequencer dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .cfg_chain_len   (cfg_chain_len),
        .cfg_shift_wft   (cfg_shift_wft),
        .cfg_capture_wft (cfg_capture_wft),
        .vec_valid       (vec_valid),
        .vec_ready       (vec_ready),
        .vec_si          (vec_si),
        .vec_so_exp      (vec_so_exp),
        .vec_so_mask     (vec_so_mask),
        .vec_last        (vec_last),
        .scan_out_obs    (scan_out_obs),
        .tester_sync     (tester_sync),
        .wft             (wft),
        .si_drive        (si_drive),
        .capture         (capture),
        .cycle_number    (cycle_number),
        .vector_number   (vector_number),
        .busy            (busy),
        .done            (done),
        .mismatch_cnt    (mismatch_cnt),
        .fail            (fail)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        int         len;
        int         npat;
        int         stall_at;
        int         stall_len;
        int         start_at;
        logic [3:0] exp;
        logic [3:0] mask;
        logic [3:0] obs;
        string      trace;
        int         cyc;
        int         vec;
        int         mm_en;
    } vec_t;

    int   n_vec;
    int   n_miss;
    vec_t vecs[8];

    function automatic vec_t mk(input int len, input int npat, input int stall_at,
                                input int stall_len, input int start_at,
                                input logic [3:0] exp, input logic [3:0] mask,
                                input logic [3:0] obs, input string trace,
                                input int cyc, input int vec, input int mm_en);
        vec_t v;
        v.len = len; v.npat = npat; v.stall_at = stall_at; v.stall_len = stall_len;
        v.start_at = start_at; v.exp = exp; v.mask = mask; v.obs = obs;
        v.trace = trace; v.cyc = cyc; v.vec = vec; v.mm_en = mm_en;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int         leff;
        int         total;
        int         beat;
        int         stall_cnt;
        bit         fin;
        string      tr;
        logic [3:0] si_fifo[$];
        logic [3:0] exp_si;
        int         mm_exp;

        leff      = (v.len == 0) ? 1 : v.len;
        total     = leff * v.npat;
        beat      = 0;
        stall_cnt = 0;
        fin       = 1'b0;
        tr        = "";
        vec_so_exp   = v.exp;
        vec_so_mask  = v.mask;
        scan_out_obs = v.obs;

        for (int c = 0; c < 400 && !fin; c++) begin
            if (c == 0) begin
                cfg_chain_len   = 16'(v.len);
                cfg_shift_wft   = SH_WFT;
                cfg_capture_wft = CAP_WFT;
            end else begin
                // config must have been captured at start
                cfg_chain_len   = 16'd7;
                cfg_shift_wft   = 4'h3;
                cfg_capture_wft = 4'hC;
            end
            start     = (c == 0) || (c == v.start_at);
            vec_valid = (c > 0) && (stall_cnt == 0) && (beat < total);
            vec_si    = 4'(beat * 3 + 1);
            vec_last  = (beat >= total - leff);
            @(negedge clock);
            if (tester_sync) begin
                if (capture) begin
                    tr = {tr, "C"};
                    check($sformatf("v%0d cap_wft", idx), 64'(wft), 64'(CAP_WFT));
                end else begin
                    tr = {tr, "S"};
                    exp_si = (si_fifo.size() > 0) ? si_fifo.pop_front() : 4'hx;
                    check($sformatf("v%0d si_drive", idx), 64'(si_drive), 64'(exp_si));
                    check($sformatf("v%0d shift_wft", idx), 64'(wft), 64'(SH_WFT));
                end
            end else begin
                tr = {tr, "."};
            end
            if (vec_valid && vec_ready) begin
                si_fifo.push_back(vec_si);
                beat++;
                if (beat == v.stall_at) stall_cnt = v.stall_len;
            end else if (!vec_valid && stall_cnt > 0) begin
                stall_cnt--;
            end
            if (done) fin = 1'b1;
            @(posedge clock);
            #1;
        end

        start     = 1'b0;
        vec_valid = 1'b0;
        n_vec++;
        if (!fin) begin
            n_miss++;
            $display("FAIL v%0d timeout: no done within 400 cycles", idx);
        end
        n_vec++;
        if (tr != v.trace) begin
            n_miss++;
            $display("FAIL v%0d trace: got %s expected %s", idx, tr, v.trace);
        end

        mm_exp = CMP_EN ? v.mm_en : 0;
        @(negedge clock);
        check($sformatf("v%0d post done/busy/ready", idx), {61'd0, done, busy, vec_ready}, 64'd0);
        check($sformatf("v%0d cycle_number", idx), 64'(cycle_number), 64'(v.cyc));
        check($sformatf("v%0d vector_number", idx), 64'(vector_number), 64'(v.vec));
        check($sformatf("v%0d mismatch_cnt", idx), 64'(mismatch_cnt), 64'(mm_exp));
        check($sformatf("v%0d fail", idx), 64'(fail), 64'(mm_exp != 0));
        @(posedge clock);
        #1;
    endtask

    initial begin
        bit bad;
        n_vec  = 0;
        n_miss = 0;

        vecs[0] = mk(3, 2, 0, 0, -1, 4'h0, 4'h0, 4'h0, "..SSSCSSSC",  8, 2, 0);
        vecs[1] = mk(4, 1, 2, 5, -1, 4'h0, 4'hF, 4'h0, "..SS.....SSC", 5, 1, 0);
        vecs[2] = mk(1, 1, 0, 0, -1, 4'hA, 4'hF, 4'h5, "..SC",        2, 1, 4);
        vecs[3] = mk(1, 1, 0, 0, -1, 4'hA, 4'h0, 4'h5, "..SC",        2, 1, 0);
        vecs[4] = mk(0, 1, 0, 0, -1, 4'h6, 4'hF, 4'h6, "..SC",        2, 1, 0);
        vecs[5] = mk(1, 3, 0, 0, -1, 4'hA, 4'h3, 4'h5, "..SCSCSC",    6, 3, 6);
        vecs[6] = mk(3, 2, 0, 0, -1, 4'hA, 4'hF, 4'h5, "..SSSCSSSC",  8, 2, 24);
        vecs[7] = mk(2, 1, 0, 0,  2, 4'h0, 4'h0, 4'h0, "..SSC",       3, 1, 0);

        reset = 1'b1; start = 1'b0; vec_valid = 1'b0; vec_last = 1'b0;
        vec_si = '0; vec_so_exp = '0; vec_so_mask = '0; scan_out_obs = '0;
        cfg_chain_len = 16'd3; cfg_shift_wft = SH_WFT; cfg_capture_wft = CAP_WFT;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        check("reset ctl outputs", {41'd0, vec_ready, tester_sync, wft, si_drive, capture,
                                    busy, done, mismatch_cnt, fail}, 64'd0);
        check("reset counters", {cycle_number, vector_number}, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Session aborted by reset after two accepted beats, with a compare in flight.
        cfg_chain_len = 16'd4; vec_so_exp = 4'hA; vec_so_mask = 4'hF; scan_out_obs = 4'h5;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; vec_valid = 1'b1; vec_si = 4'h9; vec_last = 1'b1;
        @(posedge clock); #1;
        vec_si = 4'h6;
        @(posedge clock); #1;
        vec_valid = 1'b0; reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("abort ctl outputs", {41'd0, vec_ready, tester_sync, wft, si_drive, capture,
                                    busy, done, mismatch_cnt, fail}, 64'd0);
        check("abort counters", {cycle_number, vector_number}, 64'd0);
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (done || tester_sync || busy || mismatch_cnt != 16'd0) bad = 1'b1;
        end
        check("abort quiet", 64'(bad), 64'd0);
        @(posedge clock); #1;

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
